// File: rtl/bcd_to_binary_seq.sv
// Sequential multi-digit BCD-to-binary converter: one acc*10+digit step per clock, MSD first.
// Result, done pulse and invalid-digit flag appear DIGITS edges after start; start is ignored while busy.
module bcd_to_binary_seq #(
  parameter  int DIGITS = 4,
  localparam int BIN_W  = $clog2(10**DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  error
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [BIN_W+3:0] TEN = (BIN_W+4)'(10);

  typedef enum logic {IDLE, CONV} state_t;

  state_t                state, state_nxt;
  logic [4*DIGITS-1:0]   sreg, sreg_nxt;
  logic [BIN_W-1:0]      acc, acc_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic                  err_lat, err_lat_nxt;
  logic [BIN_W-1:0]      bin_nxt;
  logic                  error_nxt, done_nxt, busy_nxt;
  logic [3:0]            digit;
  logic                  bad;
  logic [BIN_W-1:0]      mac;

  // Product is formed at BIN_W+4 bits, then truncated back to the accumulator width.
  function automatic logic [BIN_W-1:0] mac10(input logic [BIN_W-1:0] a, input logic [3:0] d);
    logic [BIN_W+3:0] wide;
    wide = {4'b0, a} * TEN + {{BIN_W{1'b0}}, d};
    return wide[BIN_W-1:0];
  endfunction

  // The shift register presents the current digit at its top nibble.
  assign digit = sreg[4*DIGITS-1 -: 4];
  assign bad   = (digit > 4'd9);
  assign mac   = mac10(acc, digit);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      sreg    <= '0;
      acc     <= '0;
      idx     <= '0;
      err_lat <= 1'b0;
      bin_out <= '0;
      error   <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      sreg    <= sreg_nxt;
      acc     <= acc_nxt;
      idx     <= idx_nxt;
      err_lat <= err_lat_nxt;
      bin_out <= bin_nxt;
      error   <= error_nxt;
      done    <= done_nxt;
      busy    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (idx == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sreg_nxt    = sreg;
    acc_nxt     = acc;
    idx_nxt     = idx;
    err_lat_nxt = err_lat;
    bin_nxt     = bin_out;
    error_nxt   = error;
    done_nxt    = 1'b0;
    busy_nxt    = busy;
    unique case (state)
      IDLE: begin
        if (start) begin
          sreg_nxt    = bcd_in;
          acc_nxt     = '0;
          err_lat_nxt = 1'b0;
          idx_nxt     = IDX_W'(DIGITS - 1);
          busy_nxt    = 1'b1;
        end
      end
      CONV: begin
        acc_nxt  = mac;
        sreg_nxt = sreg << 4;
        if (bad) err_lat_nxt = 1'b1;
        if (idx != '0) begin
          idx_nxt = idx - IDX_W'(1);
        end else begin
          // A bad digit anywhere discards the accumulated value.
          bin_nxt   = (err_lat || bad) ? '0 : mac;
          error_nxt = err_lat || bad;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
Parametrised multi-digit BCD-to-binary converter. It is the sequential successor to the team's single-digit combinational converter.
- Takes a packed DIGITS-digit BCD word on a start pulse.
- Converts it MSD-first with one multiply-accumulate per clock (acc = acc*10 + digit).
- Returns a held binary result with a done pulse and an invalid-digit error flag.
- Sits between keypad/switch BCD entry logic and the binary datapath (comparators, PWM/ADC scaling).

Parameters:
- DIGITS, 4, number of BCD digits in bcd_in (legal 1..8).
- BIN_W, $clog2(10**DIGITS) (14 for DIGITS=4), result width. This is a localparam derived from DIGITS and is not overridable.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion; sampled on the rising edge.
- bcd_in  input  4*DIGITS  packed BCD. Digit k occupies bcd_in[4k+3:4k]; digit DIGITS-1 is most significant. Sampled only on the edge where start is accepted.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- bin_out  output  BIN_W  binary result, held until the next done.
- error  output  1  high if the last accepted word contained a digit greater than 9; held like bin_out.

Behaviour:
- Reset (reset_n=0, asynchronous, any state):
  - state=IDLE; busy=0, done=0, bin_out=0, error=0.
  - Internal accumulator, index and error latch are cleared.
  - An in-flight conversion is abandoned with no done pulse.
  - Normal operation resumes on the first edge after deassertion.
- States: IDLE and CONV.
- IDLE:
  - done is forced to 0 on every edge, except that it may be set on the same edge by the CONV to IDLE transition.
  - On start=1, latch bcd_in into the shift register, clear acc and the error latch, set idx=DIGITS-1 and busy=1, then go to CONV.
  - On start=0, outputs hold.
- CONV, one digit per edge:
  - d = digit[idx]; acc_next = acc*10 + d, truncated to BIN_W bits.
  - If d > 9, set the error latch; acc still updates, and the value is discarded at the end.
  - If idx > 0: idx decrements, stay in CONV.
  - If idx == 0:
    - bin_out <= (error latch OR current d > 9) ? 0 : acc_next.
    - error <= that same OR.
    - done <= 1, busy <= 0, go to IDLE.
- Latency: start sampled at edge E; done, bin_out and error update at edge E+DIGITS. done is high for exactly one cycle. busy is high from after E until E+DIGITS.
- Throughput:
  - start is ignored while busy=1; no queuing.
  - start asserted in the cycle where done=1 is accepted, giving back-to-back conversions every DIGITS cycles.
- bin_out and error keep their previous values throughout a conversion. They change only on the done edge or on reset.
- Width: acc*10 must be computed at BIN_W+4 bits before truncation. No overflow is possible for valid input, since 10^DIGITS-1 < 2^BIN_W.
- DIGITS=1 is legal. CONV then lasts one edge, and done follows the start edge by one cycle.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset with DIGITS=4:
  - Stimulus: reset_n low for 3 cycles while start=1 and bcd_in=16'h9999.
  - Required: busy=0, done=0, bin_out=0, error=0 throughout reset.
  - Required: no done in the 10 cycles after release with start=0.
- Maximum and minimum values:
  - start with bcd_in=16'h9999 gives done exactly 4 cycles later, bin_out=14'd9999 (0x270F), error=0.
  - A following start with 16'h0000 gives bin_out=0.
  - A following start with 16'h1234 gives bin_out=1234 (0x4D2).
- Invalid digit:
  - start with bcd_in=16'h12A4 gives done after 4 cycles with bin_out=0 and error=1.
  - A next start with 16'h0007 gives bin_out=7 and error=0.
  - error must stay 1 throughout that second conversion and clear only on its done edge.
- Handshake:
  - start with 16'h0042, then pulse start with 16'h0555 while busy: ignored, single done, bin_out=42.
  - start with 16'h0100 held in the done cycle is accepted: second done 4 cycles later, bin_out=100.
- Reset mid-conversion:
  - start with 16'h8765; assert reset_n low asynchronously (between edges) 2 cycles later.
  - Required: busy, done, bin_out and error go to 0 immediately, and no done pulse follows.
  - After release, start with 16'h0321 gives bin_out=321.
- Parameter sweep: DIGITS=1 (BIN_W=4), inputs 0..9 and 4'hF.
  - Required: done one cycle after start, bin_out equal to the input for 0..9.
  - Required: for 4'hF, bin_out=0 and error=1.
